// File: rtl/scalar_mul_sched_if.sv
// Bundle of requester, grant/done and coefficient-stream signals for scalar_mul_sched.
// The master modport is the scheduler side; slave is the requesters plus the downstream sink.
interface scalar_mul_sched_if #(
    parameter int N  = 1024,
    parameter int W  = 30,
    parameter int CW = 10
);
    logic          req0;
    logic [N-1:0]  msg0;
    logic [W-1:0]  t0;
    logic          req1;
    logic [N-1:0]  msg1;
    logic [W-1:0]  t1;
    logic [1:0]    gnt;
    logic          busy;
    logic          owner;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_data;
    logic [CW-1:0] out_idx;
    logic          out_last;
    logic [1:0]    done;

    modport master (
        input  req0, msg0, t0, req1, msg1, t1, out_ready,
        output gnt, busy, owner, out_valid, out_data, out_idx, out_last, done
    );

    modport slave (
        output req0, msg0, t0, req1, msg1, t1, out_ready,
        input  gnt, busy, owner, out_valid, out_data, out_idx, out_last, done
    );
endinterface

// File: rtl/scalar_mul_sched.sv
// Round-robin scheduler for the shared scalar-by-binary-message multiplier: grants one of two
// requesters, latches its message and scalar, then streams N coefficients (t or 0) on valid/ready.
module scalar_mul_sched #(
    parameter int N  = 1024,
    parameter int W  = 30,
    parameter int CW = 10
) (
    input logic                clk,
    input logic                reset,
    scalar_mul_sched_if.master bus
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_STREAM,
        ST_DONE
    } state_e;

    localparam logic [CW-1:0] LAST_IDX = CW'(N - 1);

    state_e        state_q, state_d;
    logic [N-1:0]  msg_q, msg_d;
    logic [W-1:0]  t_q, t_d;
    logic [CW-1:0] idx_q, idx_d;
    logic [W-1:0]  data_q, data_d;
    logic          valid_q, valid_d;
    logic          last_q, last_d;
    logic [1:0]    gnt_q, gnt_d;
    logic [1:0]    done_q, done_d;
    logic          busy_q, busy_d;
    logic          owner_q, owner_d;
    logic          pref_q, pref_d;

    logic          grant_sel;
    logic [N-1:0]  grant_msg;
    logic [W-1:0]  grant_t;
    logic [CW-1:0] idx_inc;

    always_comb begin
        state_d = state_q;
        msg_d   = msg_q;
        t_d     = t_q;
        idx_d   = idx_q;
        data_d  = data_q;
        valid_d = valid_q;
        last_d  = last_q;
        gnt_d   = '0;
        done_d  = '0;
        busy_d  = busy_q;
        owner_d = owner_q;
        pref_d  = pref_q;

        // pref_q is only consulted on a tie; a lone request always wins
        grant_sel = (bus.req0 && bus.req1) ? pref_q : bus.req1;
        grant_msg = grant_sel ? bus.msg1 : bus.msg0;
        grant_t   = grant_sel ? bus.t1 : bus.t0;
        idx_inc   = idx_q + CW'(1);

        case (state_q)
            ST_IDLE: begin
                if (bus.req0 || bus.req1) begin
                    gnt_d   = grant_sel ? 2'b10 : 2'b01;
                    msg_d   = grant_msg;
                    t_d     = grant_t;
                    owner_d = grant_sel;
                    busy_d  = 1'b1;
                    idx_d   = '0;
                    valid_d = 1'b1;
                    data_d  = grant_msg[0] ? grant_t : '0;
                    last_d  = 1'b0;
                    state_d = ST_STREAM;
                end
            end
            ST_STREAM: begin
                if (valid_q && bus.out_ready) begin
                    if (idx_q == LAST_IDX) begin
                        valid_d = 1'b0;
                        last_d  = 1'b0;
                        done_d  = owner_q ? 2'b10 : 2'b01;
                        state_d = ST_DONE;
                    end else begin
                        idx_d  = idx_inc;
                        data_d = msg_q[idx_inc] ? t_q : '0;
                        last_d = (idx_inc == LAST_IDX);
                    end
                end
            end
            ST_DONE: begin
                busy_d  = 1'b0;
                pref_d  = ~owner_q;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            msg_q   <= '0;
            t_q     <= '0;
            idx_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            gnt_q   <= '0;
            done_q  <= '0;
            busy_q  <= 1'b0;
            owner_q <= 1'b0;
            pref_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            msg_q   <= msg_d;
            t_q     <= t_d;
            idx_q   <= idx_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            last_q  <= last_d;
            gnt_q   <= gnt_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
            owner_q <= owner_d;
            pref_q  <= pref_d;
        end
    end

    assign bus.gnt       = gnt_q;
    assign bus.busy      = busy_q;
    assign bus.owner     = owner_q;
    assign bus.out_valid = valid_q;
    assign bus.out_data  = data_q;
    assign bus.out_idx   = idx_q;
    assign bus.out_last  = last_q;
    assign bus.done      = done_q;

endmodule

// File: doc/scalar_mul_sched.md
Name: scalar_mul_sched

Overview:
- Round-robin scheduler and sequencer for the shared scalar-by-binary-message multiply resource in the HE datapath.
- Two requesters (e.g. encrypt path, key-gen path) each present an N-bit message and a W-bit scalar t.
- The block grants one requester, latches its job, then streams N coefficients (t where the message bit is 1, else 0) on a valid/ready output.
- A per-requester done pulse marks the end of each job.

Parameters:
N, 1024, coefficients per job (message width); power of two, >= 2
W, 30, coefficient/scalar width
CW, 10, index width = log2(N)

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-high reset
req0  input  1  requester 0 job request; held high until gnt[0]
msg0  input  N  requester 0 message bits; bit i selects coefficient i
t0  input  W  requester 0 scalar
req1  input  1  requester 1 job request
msg1  input  N  requester 1 message bits
t1  input  W  requester 1 scalar
gnt  output  2  one-cycle grant pulse; msg/t of the granted requester captured on the same edge
busy  output  1  high from grant through the done cycle
owner  output  1  index of requester owning the current job
out_valid  output  1  coefficient beat valid
out_ready  input  1  downstream accepts beat
out_data  output  W  coefficient value
out_idx  output  CW  coefficient index of current beat
out_last  output  1  high with beat index N-1
done  output  2  one-cycle pulse to owner after final beat accepted

Behaviour:
- Reset (asserted at any time, including mid-job) forces the following, with no done pulse for the aborted job:
  - State IDLE.
  - All outputs 0.
  - Internal message/scalar registers 0.
  - Round-robin pointer set to prefer requester 0.
- States and transitions:
  - IDLE: if no req, remain in IDLE.
  - IDLE, arbitration when one or more req is high:
    - Only one requester high: grant it.
    - Both high: grant the preferred requester.
  - IDLE, on the grant edge:
    - gnt[g]=1 for exactly one cycle.
    - msg_g and t_g latched.
    - owner=g, busy=1, out_idx=0, out_valid=1; next state STREAM.
  - STREAM: out_valid=1; out_data = t_r if msg_r[out_idx]==1 else 0.
    - out_data, out_idx and out_last are registered and stable while out_valid && !out_ready.
  - STREAM, on each edge with out_valid && out_ready:
    - If out_idx<N-1: out_idx increments and the next coefficient is presented; no bubble cycles.
    - If out_idx==N-1: out_valid=0, done[owner]=1, state DONE.
  - DONE: one cycle.
    - done pulse high, busy still 1.
    - Round-robin pointer set to prefer !owner.
    - Next edge: IDLE, done=0, busy=0.
- out_last = out_valid && (out_idx==N-1).
- Latency:
  - req high in IDLE at edge k -> gnt and first beat (idx 0) valid in cycle after k.
  - With out_ready held high, a job occupies N STREAM cycles plus 1 DONE cycle.
  - The earliest next grant is the first edge after returning to IDLE, i.e. a 2-cycle gap between the final handshake and the next job's first beat.
- Requests:
  - A req deasserted before its grant is dropped without side effects.
  - req, msg and t changes after grant do not affect the running job (latched copies are used).
  - A req arriving during a job waits; it is evaluated in IDLE.
- Width rules: no arithmetic on data; out_data is an exact copy of t_r or all zeros; t=0 still produces N zero beats plus done.
- out_ready high while out_valid low is ignored.
- gnt and done never assert for both requesters in the same cycle.

Test Plan:
- Single job, ready held high (override N=8, W=30):
  - Stimulus: req0=1, msg0=8'b1010_0110, t0=30'h1234567.
  - Required: gnt=2'b01 for one cycle; beats idx0..7 = 0,h1234567,h1234567,0,0,h1234567,0,h1234567; out_last on idx7; done=2'b01 one cycle after; busy low the cycle after that.
- Backpressure (N=8):
  - Stimulus: out_ready toggles 1,0,0,1,...
  - Required: out_data/out_idx held constant through every stalled cycle; exactly 8 accepted beats in order; no duplicate or skipped index.
- Simultaneous requests, req0=req1=1 held through both jobs:
  - Required: first gnt=01 (post-reset preference), then gnt=10; then gnt=01 again if req0 still high.
  - Required: owner and done match each grant; gap of 2 cycles between last beat and next first beat.
- Request withdrawal:
  - Stimulus: req1 pulses for one cycle while the block is busy with requester 0.
  - Required: no grant to requester 1; IDLE after done.
- Reset mid-STREAM (N=1024):
  - Stimulus: reset asserted asynchronously at beat idx 500.
  - Required: outputs 0 immediately, no done pulse; a new req0 after release restarts at idx 0.
- Edge data (N=8):
  - Stimulus: t0=30'h3FFFFFFF with msg0 all ones, then t0=0 with msg0 all ones.
  - Required: all 8 beats 30'h3FFFFFFF; then all 8 beats 0 and done still asserted.
